// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB to HSV converter: S0 unpack/max/min, S1 operand setup,
// CW restoring-divider stages, OUT hue fix-up. One pixel per clock, global stall.
module rgb2hsv_pipe #(
   parameter int CW      = 8,
   parameter int IN_MODE = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3*CW-1:0] in_rgb,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [CW-1:0]   out_h,
   output logic [CW-1:0]   out_s,
   output logic [CW-1:0]   out_v,
   output logic [15:0]     out_hsv565,
   output logic            out_valid,
   input  logic            out_ready
);
   localparam int DW = 2*CW + 6;
   localparam int NS = CW + 1;
   localparam logic [DW-1:0] S_SCALE = DW'((1 << CW) - 1);
   localparam logic [DW-1:0] H_SCALE = DW'(60);

   logic advance;
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   logic [CW-1:0] r_in, g_in, b_in, max_in, min_in;

   generate
      if (IN_MODE == 1) begin : g_unpack565
         assign r_in = CW'({in_rgb[15:11], in_rgb[15:13]});
         assign g_in = CW'({in_rgb[10:5], in_rgb[10:9]});
         assign b_in = CW'({in_rgb[4:0], in_rgb[4:2]});
      end else begin : g_unpack_rgb
         assign r_in = in_rgb[3*CW-1:2*CW];
         assign g_in = in_rgb[2*CW-1:CW];
         assign b_in = in_rgb[CW-1:0];
      end
   endgenerate

   always_comb begin
      max_in = r_in;
      if (g_in > max_in) max_in = g_in;
      if (b_in > max_in) max_in = b_in;
      min_in = r_in;
      if (g_in < min_in) min_in = g_in;
      if (b_in < min_in) min_in = b_in;
   end

   logic          s0_valid;
   logic [CW-1:0] s0_r, s0_g, s0_b, s0_max, s0_min;

   logic [CW-1:0] delta, d_abs;
   logic [8:0]    base_c;
   logic          sign_c, zero_c;

   // Sector priority R, G, B; sign set means the offset is subtracted from base.
   always_comb begin
      delta  = s0_max - s0_min;
      zero_c = (delta == '0);
      base_c = 9'd0;
      sign_c = 1'b0;
      d_abs  = '0;
      if (s0_r == s0_max) begin
         if (s0_g >= s0_b) begin
            d_abs = s0_g - s0_b;
         end else begin
            base_c = 9'd360;
            sign_c = 1'b1;
            d_abs  = s0_b - s0_g;
         end
      end else if (s0_g == s0_max) begin
         base_c = 9'd120;
         if (s0_b >= s0_r) begin
            d_abs = s0_b - s0_r;
         end else begin
            sign_c = 1'b1;
            d_abs  = s0_r - s0_b;
         end
      end else begin
         base_c = 9'd240;
         if (s0_r >= s0_g) begin
            d_abs = s0_r - s0_g;
         end else begin
            sign_c = 1'b1;
            d_abs  = s0_g - s0_r;
         end
      end
      if (zero_c) begin
         base_c = 9'd0;
         sign_c = 1'b0;
      end
   end

   // Index 0 is the S1 register, index k the D_k register.
   logic [DW-1:0] st_hrem [NS];
   logic [DW-1:0] st_srem [NS];
   logic [CW-1:0] st_hden [NS];
   logic [CW-1:0] st_sden [NS];
   logic [CW-1:0] st_hq   [NS];
   logic [CW-1:0] st_sq   [NS];
   logic [CW-1:0] st_v    [NS];
   logic [8:0]    st_base [NS];
   logic          st_sign [NS];
   logic          st_zero [NS];
   logic          st_valid[NS];

   logic [DW-1:0] nx_hrem [NS];
   logic [DW-1:0] nx_srem [NS];
   logic [CW-1:0] nx_hden [NS];
   logic [CW-1:0] nx_sden [NS];
   logic [CW-1:0] nx_hq   [NS];
   logic [CW-1:0] nx_sq   [NS];
   logic [CW-1:0] nx_v    [NS];
   logic [8:0]    nx_base [NS];
   logic          nx_sign [NS];
   logic          nx_zero [NS];
   logic          nx_valid[NS];

   always_comb begin
      nx_hrem[0]  = zero_c ? '0 : DW'(d_abs) * H_SCALE;
      nx_srem[0]  = zero_c ? '0 : DW'(delta) * S_SCALE;
      nx_hden[0]  = zero_c ? CW'(1) : delta;
      nx_sden[0]  = zero_c ? CW'(1) : s0_max;
      nx_hq[0]    = '0;
      nx_sq[0]    = '0;
      nx_v[0]     = s0_max;
      nx_base[0]  = base_c;
      nx_sign[0]  = sign_c;
      nx_zero[0]  = zero_c;
      nx_valid[0] = s0_valid;
      // Stage k resolves quotient bit CW-k by trial subtraction of the shifted divisor.
      for (int k = 1; k < NS; k++) begin
         nx_hden[k]  = st_hden[k-1];
         nx_sden[k]  = st_sden[k-1];
         nx_v[k]     = st_v[k-1];
         nx_base[k]  = st_base[k-1];
         nx_sign[k]  = st_sign[k-1];
         nx_zero[k]  = st_zero[k-1];
         nx_valid[k] = st_valid[k-1];
         if (st_hrem[k-1] >= (DW'(st_hden[k-1]) << (CW - k))) begin
            nx_hrem[k] = st_hrem[k-1] - (DW'(st_hden[k-1]) << (CW - k));
            nx_hq[k]   = {st_hq[k-1][CW-2:0], 1'b1};
         end else begin
            nx_hrem[k] = st_hrem[k-1];
            nx_hq[k]   = {st_hq[k-1][CW-2:0], 1'b0};
         end
         if (st_srem[k-1] >= (DW'(st_sden[k-1]) << (CW - k))) begin
            nx_srem[k] = st_srem[k-1] - (DW'(st_sden[k-1]) << (CW - k));
            nx_sq[k]   = {st_sq[k-1][CW-2:0], 1'b1};
         end else begin
            nx_srem[k] = st_srem[k-1];
            nx_sq[k]   = {st_sq[k-1][CW-2:0], 1'b0};
         end
      end
   end

   logic [9:0]    hdeg;
   logic [CW-1:0] h_fin, s_fin;

   always_comb begin
      if (st_sign[NS-1]) hdeg = {1'b0, st_base[NS-1]} - 10'(st_hq[NS-1]);
      else               hdeg = {1'b0, st_base[NS-1]} + 10'(st_hq[NS-1]);
      if (hdeg == 10'd360 || st_zero[NS-1]) hdeg = 10'd0;
      h_fin = CW'(hdeg >> 1);
      s_fin = st_zero[NS-1] ? '0 : st_sq[NS-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_r     <= '0;
         s0_g     <= '0;
         s0_b     <= '0;
         s0_max   <= '0;
         s0_min   <= '0;
         for (int k = 0; k < NS; k++) begin
            st_hrem[k]  <= '0;
            st_srem[k]  <= '0;
            st_hden[k]  <= '0;
            st_sden[k]  <= '0;
            st_hq[k]    <= '0;
            st_sq[k]    <= '0;
            st_v[k]     <= '0;
            st_base[k]  <= '0;
            st_sign[k]  <= 1'b0;
            st_zero[k]  <= 1'b0;
            st_valid[k] <= 1'b0;
         end
         out_h      <= '0;
         out_s      <= '0;
         out_v      <= '0;
         out_hsv565 <= '0;
         out_valid  <= 1'b0;
      end else if (advance) begin
         s0_valid <= in_valid;
         s0_r     <= r_in;
         s0_g     <= g_in;
         s0_b     <= b_in;
         s0_max   <= max_in;
         s0_min   <= min_in;
         for (int k = 0; k < NS; k++) begin
            st_hrem[k]  <= nx_hrem[k];
            st_srem[k]  <= nx_srem[k];
            st_hden[k]  <= nx_hden[k];
            st_sden[k]  <= nx_sden[k];
            st_hq[k]    <= nx_hq[k];
            st_sq[k]    <= nx_sq[k];
            st_v[k]     <= nx_v[k];
            st_base[k]  <= nx_base[k];
            st_sign[k]  <= nx_sign[k];
            st_zero[k]  <= nx_zero[k];
            st_valid[k] <= nx_valid[k];
         end
         out_h      <= h_fin;
         out_s      <= s_fin;
         out_v      <= st_v[NS-1];
         out_hsv565 <= {h_fin[7:3], s_fin[7:2], st_v[NS-1][7:3]};
         out_valid  <= st_valid[NS-1];
      end
   end
endmodule

// File: doc/rgb2hsv_pipe.md
# rgb2hsv_pipe

Parametrised, fully pipelined RGB-to-HSV converter for the video path. It accepts one pixel per clock under a valid/ready handshake and produces Hue (degrees/2), Saturation and Value after a fixed latency. Inputs are either CW-bit per-channel RGB or packed RGB565. Division runs in two pipelined restoring dividers, so throughput is one pixel per clock, and back-pressure stalls the whole pipeline.

## Interface
- CW, 8: channel width for R/G/B and for S/V outputs; legal range 8..12.
- IN_MODE, 0: 0 = `in_rgb` = {R,G,B}, each CW bits; 1 = `in_rgb[15:0]` is RGB565 (requires CW=8).
- clk  in  1  Pipeline clock; the block has one clock.
- rst_n  in  1  Reset; asynchronous, active-low.
- in_rgb  in  3*CW  Input pixel.
- in_valid  in  1  Input pixel valid.
- in_ready  out  1  Block accepts a pixel this cycle.
- out_h  out  CW  Hue, degrees/2, range 0..179.
- out_s  out  CW  Saturation, 0..2^CW-1.
- out_v  out  CW  Value = max(R,G,B).
- out_hsv565  out  16  {out_h[7:3], out_s[7:2], out_v[7:3]}; valid for CW=8 only.
- out_valid  out  1  Output valid.
- out_ready  in  1  Downstream accepts output.

## Operation
- Unpacking in mode 1 uses MSB replication: R = {p[15:11], p[15:13]}, G = {p[10:5], p[10:9]}, B = {p[4:0], p[4:2]}.
- Definitions: max and min are taken over R, G, B. delta = max - min.
- V = max.
- When delta = 0: H = 0 and S = 0.
- Otherwise: S = floor((2^CW-1)*delta/max).
- Hue sector is chosen by priority R, then G, then B, where a channel is selected if it equals max. The offset is off = floor(60*|d|/delta), with d defined per sector:
  - R max, G>=B: hdeg = off, with d = G-B.
  - R max, G<B: hdeg = 360 - off, with d = B-G.
  - G max: hdeg = 120 ± off, with d = B-R; the sign follows d.
  - B max: hdeg = 240 ± off, with d = R-G; the sign follows d.
- If hdeg = 360, it wraps to 0.
- out_h = hdeg >> 1, zero-extended to CW bits.
- Both quotients are CW bits wide. Hue quotient is ≤ 60 and S quotient is ≤ 2^CW-1, so neither overflows.
- Pipeline structure:
  - S0 registers the unpacked pixel, max and min.
  - S1 forms both dividends, both divisors, the hue base and the sign. The hue divisor is delta; the S divisor is max. When delta = 0, both divisors are forced to 1 and both dividends to 0.
  - D1..D_CW each resolve one quotient bit per divider, MSB first. Each stage carries base, sign, V and the delta=0 flag alongside the divider state.
  - OUT applies the hue add/subtract, the 360 wrap, and >>1, then registers the outputs.
- Each stage carries its own valid bit.
- Advance rule: advance = out_ready | ~out_valid. When advance = 0, every stage holds, including data and valid.
  - Bubbles are not collapsed.
  - in_ready = advance.
  - A pixel is accepted when in_valid & in_ready.
- Reset: all valid bits and all pipeline registers clear asynchronously. out_h, out_s, out_v, out_hsv565 and out_valid reset to 0, so in_ready = 1 during and after reset.
- Outputs hold their value while out_valid & ~out_ready.

## Timing
- Latency from acceptance to out_valid is L = CW + 3 cycles of advance; L = 11 for CW = 8.
- Throughput is one pixel per clock while out_ready = 1.
- Stall response:
  - out_ready low with out_valid high freezes the pipe in the same cycle; in_ready drops combinationally.
  - No pixel is dropped or duplicated across any stall pattern.
  - Order is preserved.
- Reset mid-stream: all in-flight pixels are discarded. out_valid is 0 from assertion until the first post-reset pixel completes L cycles.
- Simultaneous accept and emit on the same edge are both legal.

## Test plan
- CW=8, mode 0, single pixels:
  - (255,0,0) → H=0, S=255, V=255.
  - (0,255,0) → H=60.
  - (0,0,255) → H=120.
  - Each appears exactly 11 cycles after acceptance.
- Gray (128,128,128) → H=0, S=0, V=128.
- (200,100,50) → H=10, S=191, V=200.
- (255,0,1) → off=0, hdeg 360 wraps → H=0, S=255, V=255.
- Ties: (100,100,0) → R priority, H=30; (0,100,100) → G sector, H=90.
- Mode 1:
  - 16'hF800 → H=0, S=255, V=255.
  - 16'h07E0 → H=60.
  - 16'h0000 → all outputs 0.
  - out_hsv565 matches the packing rule.
- Stream of 64 random pixels checked against a software model.
  - out_ready toggles pseudo-randomly, including 5-cycle low bursts.
  - Required: identical ordered output sequence, and outputs stable while stalled.
- Assert rst_n low for 2 cycles while 6 pixels are in flight:
  - out_valid is 0 immediately and no stale pixel ever emerges.
  - The first new pixel appears L cycles after its acceptance.
